// File: rtl/ppu_oam_dma.sv
// Sprite DMA and OAM write-port arbiter: decodes $2003/$2004/$4014 and copies a 256-byte CPU page into OAM.
// oam_we is a one-clock25 pulse the cycle after its ce_cpu; the CPU is stalled via cpu_halt for 513/514 ce_cpu periods per DMA.
module ppu_oam_dma #(
  parameter logic [15:0] DMA_REG     = 16'h4014,
  parameter logic [15:0] OAMADDR_REG = 16'h2003,
  parameter logic [15:0] OAMDATA_REG = 16'h2004
) (
  input  logic        clock25,
  input  logic        reset_n,
  input  logic        ce_cpu,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_w,
  input  logic [7:0]  cpu_din,
  output logic        cpu_halt,
  output logic [15:0] dma_a,
  output logic        dma_rd,
  output logic        dma_busy,
  output logic [7:0]  oam_wa,
  output logic [7:0]  oam_wd,
  output logic        oam_we,
  output logic [7:0]  oam_addr
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HALT  = 3'd1,
    S_ALIGN = 3'd2,
    S_READ  = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t      state, state_nxt;
  logic        parity;
  logic [7:0]  idx, idx_nxt;
  logic [7:0]  page, page_nxt;
  logic        cpu_halt_nxt, dma_rd_nxt, dma_busy_nxt, oam_we_nxt;
  logic [15:0] dma_a_nxt;
  logic [7:0]  oam_wa_nxt, oam_wd_nxt, oam_addr_nxt;

  always_ff @(posedge clock25) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      parity   <= 1'b0;
      idx      <= 8'h00;
      page     <= 8'h00;
      cpu_halt <= 1'b0;
      dma_a    <= 16'h0000;
      dma_rd   <= 1'b0;
      dma_busy <= 1'b0;
      oam_wa   <= 8'h00;
      oam_wd   <= 8'h00;
      oam_we   <= 1'b0;
      oam_addr <= 8'h00;
    end else begin
      state    <= state_nxt;
      parity   <= parity ^ ce_cpu;
      idx      <= idx_nxt;
      page     <= page_nxt;
      cpu_halt <= cpu_halt_nxt;
      dma_a    <= dma_a_nxt;
      dma_rd   <= dma_rd_nxt;
      dma_busy <= dma_busy_nxt;
      oam_wa   <= oam_wa_nxt;
      oam_wd   <= oam_wd_nxt;
      oam_we   <= oam_we_nxt;
      oam_addr <= oam_addr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (ce_cpu) begin
      case (state)
        S_IDLE:  if (cpu_w && cpu_a == DMA_REG) state_nxt = S_HALT;
        // odd parity on the dummy cycle costs one extra alignment cycle
        S_HALT:  state_nxt = parity ? S_ALIGN : S_READ;
        S_ALIGN: state_nxt = S_READ;
        S_READ:  state_nxt = S_WRITE;
        S_WRITE: state_nxt = (idx == 8'hFF) ? S_DONE : S_READ;
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    idx_nxt      = idx;
    page_nxt     = page;
    cpu_halt_nxt = cpu_halt;
    dma_a_nxt    = dma_a;
    dma_rd_nxt   = dma_rd;
    dma_busy_nxt = dma_busy;
    oam_wa_nxt   = oam_wa;
    oam_wd_nxt   = oam_wd;
    oam_we_nxt   = 1'b0;
    oam_addr_nxt = oam_addr;
    if (ce_cpu) begin
      case (state)
        S_IDLE: begin
          if (cpu_w) begin
            if (cpu_a == OAMADDR_REG) begin
              oam_addr_nxt = cpu_dout;
            end else if (cpu_a == OAMDATA_REG) begin
              oam_wa_nxt   = oam_addr;
              oam_wd_nxt   = cpu_dout;
              oam_we_nxt   = 1'b1;
              oam_addr_nxt = oam_addr + 8'd1;
            end else if (cpu_a == DMA_REG) begin
              page_nxt     = cpu_dout;
              idx_nxt      = 8'h00;
              cpu_halt_nxt = 1'b1;
              dma_busy_nxt = 1'b1;
            end
          end
        end
        S_READ: begin
          dma_a_nxt  = {page, idx};
          dma_rd_nxt = 1'b1;
        end
        S_WRITE: begin
          // OAM target is offset from OAMADDR; OAMADDR itself is left untouched
          dma_rd_nxt = 1'b0;
          oam_wa_nxt = oam_addr + idx;
          oam_wd_nxt = cpu_din;
          oam_we_nxt = 1'b1;
          if (idx != 8'hFF) idx_nxt = idx + 8'd1;
        end
        S_DONE: begin
          cpu_halt_nxt = 1'b0;
          dma_busy_nxt = 1'b0;
          dma_a_nxt    = 16'h0000;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/ppu_oam_dma.md
Name: ppu_oam_dma

Overview:
- Sprite-DMA controller and OAM write arbiter between the CPU and the PPU's 256-byte OAM.
- Decodes CPU writes to $2003 (OAMADDR), $2004 (OAMDATA) and $4014 (OAMDMA).
- On a $4014 write it halts the CPU and copies page {data,8'h00..8'hFF} from the CPU bus into OAM.
- Owns the single OAM write port. The PPU sprite evaluator keeps its read-only port (oama/oamd) untouched.

Parameters:
- DMA_REG, 16'h4014, CPU address that triggers DMA.
- OAMADDR_REG, 16'h2003, CPU address of the OAM address register.
- OAMDATA_REG, 16'h2004, CPU address of the OAM data port.

Ports:
- clock25  in  1  system clock (25 MHz, VGA pixel clock)
- reset_n  in  1  synchronous active-low reset
- ce_cpu  in  1  CPU clock-enable pulse from ppu; all state advances only when ce_cpu=1
- cpu_a  in  16  CPU address bus
- cpu_dout  in  8  CPU write data
- cpu_w  in  1  CPU write strobe, qualified by ce_cpu
- cpu_din  in  8  CPU-bus read data (returns data for dma_a one ce_cpu later)
- cpu_halt  out  1  holds CPU; CPU must not advance while 1
- dma_a  out  16  bus address driven while the DMA owns the bus
- dma_rd  out  1  bus read request from the DMA
- dma_busy  out  1  DMA in progress (status/debug)
- oam_wa  out  8  OAM write address
- oam_wd  out  8  OAM write data
- oam_we  out  1  OAM write enable, one clock25 pulse
- oam_addr  out  8  current OAMADDR register value

Behaviour:
- Reset: all outputs 0, state=IDLE, parity=0, idx=0, page=0.
- Internal parity bit toggles on every ce_cpu.
- States and transitions (each advances only on ce_cpu):
  - IDLE:
    - cpu_w & cpu_a==OAMADDR_REG: oam_addr<=cpu_dout.
    - cpu_w & cpu_a==OAMDATA_REG: oam_wa<=oam_addr, oam_wd<=cpu_dout, oam_we pulse, oam_addr<=oam_addr+1 (8-bit wrap FF->00).
    - cpu_w & cpu_a==DMA_REG: page<=cpu_dout, idx<=0, cpu_halt<=1, dma_busy<=1, ->HALT.
  - HALT: one dummy cycle. ->ALIGN if parity==1 at this ce, else ->READ.
  - ALIGN: one extra dummy cycle, ->READ.
  - READ: dma_a<={page,idx}, dma_rd<=1, ->WRITE.
  - WRITE: dma_rd<=0; oam_wa<=oam_addr+idx (8-bit wrap), oam_wd<=cpu_din, oam_we pulse. If idx==255 ->DONE, else idx<=idx+1, ->READ.
  - DONE: cpu_halt<=0, dma_busy<=0, dma_a<=0, ->IDLE.
- Timing and counts:
  - CPU-stall length, HALT through WRITE inclusive: 513 ce_cpu periods on even alignment, 514 on odd.
  - Exactly 256 oam_we pulses per DMA.
  - oam_addr is unchanged at the end of the DMA.
- oam_we is high for exactly one clock25 cycle, the cycle after the qualifying ce_cpu. It is 0 at all other times.
- Arbitration:
  - When dma_busy=1, CPU writes to $2003/$2004/$4014 are ignored; the CPU is halted and any such strobe is spurious.
  - The DMA has absolute priority on the OAM write port.
- Page FF wraps the address to FFxx only; the high byte never carries.
- $2004 and $4014 asserted in the same ce_cpu cannot occur (single address). No special handling.
- reset_n=0 mid-DMA: abort immediately, cpu_halt=0, no further oam_we, oam_addr=0.
- ce_cpu held 0: all state frozen and outputs held, except that oam_we still self-clears after one clock.

Test Plan:
- Write $2003=8'h10, then $2004=8'hAA and $2004=8'hBB -> oam_we pulses at oam_wa 10 and 11 with data AA and BB; oam_addr ends at 8'h12.
- Write $4014=8'h02 on an even-parity cycle with memory model din=low byte of address -> 256 writes with oam_wa=idx and oam_wd=idx; dma_a spans 0200..02FF; cpu_halt lasts 513 ce_cpu periods.
- Same transfer started on an odd-parity cycle -> cpu_halt lasts 514 ce_cpu periods; data identical.
- oam_addr=8'hF0, then $4014=8'h03 -> first write at oam_wa=F0 with data from 0300, write 16 at oam_wa=00 (wrap), last write at oam_wa=EF; oam_addr remains F0.
- Assert reset_n=0 after 100 DMA writes -> next clock cpu_halt=0, dma_busy=0, oam_we=0; no further writes after release.
- Pulse $2004 writes while dma_busy=1 -> no extra oam_we beyond 256; oam_addr unchanged.
